// File: rtl/logistic_bifurcation_sweeper.sv
// rtl/logistic_bifurcation_sweeper.sv - logistic-map bifurcation sweep emitting (col,row) plot points
module logistic_bifurcation_sweeper #(
  parameter int COLS = 640,
  parameter int ROWS = 480
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start_i,
  input  logic [17:0] mu_start_i,
  input  logic [17:0] mu_step_i,
  input  logic [16:0] x0_i,
  input  logic [8:0]  warmup_i,
  input  logic [8:0]  samples_i,
  output logic        pt_valid_o,
  output logic [9:0]  pt_col_o,
  output logic [9:0]  pt_row_o,
  input  logic        pt_ready_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [9:0] LAST_COL = 10'(COLS - 1);
  localparam logic [9:0] ROWS_W   = 10'(ROWS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TERM,
    S_MULT,
    S_EMIT,
    S_NEXT
  } state_t;

  state_t      state_q;
  logic [17:0] mu_q;
  logic [17:0] mu_step_q;
  logic [16:0] x0_q;
  logic [8:0]  warmup_q;
  logic [8:0]  samples_q;
  logic [9:0]  col_q;
  logic [15:0] x_q;
  logic [16:0] t_q;
  logic [10:0] iter_q;
  logic        pt_valid_q;
  logic [9:0]  pt_col_q;
  logic [9:0]  pt_row_q;
  logic        busy_q;
  logic        done_q;

  logic [15:0] x_clamp_d;
  logic [33:0] term_prod;
  logic [16:0] t_d;
  logic [34:0] mul_prod;
  logic [18:0] mul_shift;
  logic [15:0] x_mul_d;
  logic [25:0] row_prod;
  logic [9:0]  row_d;
  logic [10:0] iter_d;
  logic [10:0] iter_total;
  logic [10:0] iter_warm;
  logic [18:0] mu_sum;
  logic [17:0] mu_d;

  // Datapath: x(1-x) term, mu*t with saturation, row scaling and mu stepping.
  // x_q never exceeds 0xFFFF, so (0x10000 - x) always fits in 17 bits.
  always_comb begin
    x_clamp_d  = x0_q[16] ? 16'hFFFF : x0_q[15:0];
    term_prod  = {18'b0, x_q} * {17'b0, (17'h10000 - {1'b0, x_q})};
    t_d        = 17'(term_prod >> 16);
    mul_prod   = {17'b0, mu_q} * {18'b0, t_q};
    mul_shift  = 19'(mul_prod >> 16);
    x_mul_d    = (mul_shift > 19'h0FFFF) ? 16'hFFFF : mul_shift[15:0];
    row_prod   = {10'b0, x_mul_d} * {16'b0, ROWS_W};
    row_d      = 10'(row_prod >> 16);
    iter_d     = iter_q + 11'd1;
    iter_warm  = {2'b0, warmup_q};
    iter_total = {2'b0, warmup_q} + {2'b0, samples_q};
    mu_sum     = {1'b0, mu_q} + {1'b0, mu_step_q};
    mu_d       = mu_sum[18] ? 18'h3FFFF : mu_sum[17:0];
  end

  // Sweep sequencer with registered stream and status outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      mu_q       <= '0;
      mu_step_q  <= '0;
      x0_q       <= '0;
      warmup_q   <= '0;
      samples_q  <= '0;
      col_q      <= '0;
      x_q        <= '0;
      t_q        <= '0;
      iter_q     <= '0;
      pt_valid_q <= 1'b0;
      pt_col_q   <= '0;
      pt_row_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            mu_q      <= mu_start_i;
            mu_step_q <= mu_step_i;
            x0_q      <= x0_i;
            warmup_q  <= warmup_i;
            samples_q <= samples_i;
            col_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          x_q     <= x_clamp_d;
          iter_q  <= '0;
          state_q <= S_TERM;
        end
        S_TERM: begin
          t_q     <= t_d;
          state_q <= S_MULT;
        end
        S_MULT: begin
          x_q    <= x_mul_d;
          iter_q <= iter_d;
          if (iter_d <= iter_warm) begin
            state_q <= S_TERM;
          end else if (iter_d <= iter_total) begin
            pt_valid_q <= 1'b1;
            pt_col_q   <= col_q;
            pt_row_q   <= row_d;
            state_q    <= S_EMIT;
          end else begin
            state_q <= S_NEXT;
          end
        end
        S_EMIT: begin
          if (pt_ready_i) begin
            pt_valid_q <= 1'b0;
            state_q    <= (iter_q < iter_total) ? S_TERM : S_NEXT;
          end
        end
        S_NEXT: begin
          if (col_q == LAST_COL) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            col_q   <= col_q + 10'd1;
            mu_q    <= mu_d;
            state_q <= S_LOAD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pt_valid_o = pt_valid_q;
  assign pt_col_o   = pt_col_q;
  assign pt_row_o   = pt_row_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_logistic_bifurcation_sweeper.sv
// tb/tb_logistic_bifurcation_sweeper.sv - scoreboard bench for logistic_bifurcation_sweeper
module tb_logistic_bifurcation_sweeper;

  localparam int TB_COLS = 20;
  localparam int BUDGET  = 20000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [17:0] mu_start;
  logic [17:0] mu_step;
  logic [16:0] x0;
  logic [8:0]  warmup;
  logic [8:0]  samples;
  logic        pt_valid_o;
  logic [9:0]  pt_col_o;
  logic [9:0]  pt_row_o;
  logic        pt_ready;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  int done_cyc;
  int n_points;
  bit got_done;
  int exp_col[$];
  int exp_row[$];

  always #5 CLK = ~CLK;

  logistic_bifurcation_sweeper #(.COLS(TB_COLS), .ROWS(480)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start_i    (start),
    .mu_start_i (mu_start),
    .mu_step_i  (mu_step),
    .x0_i       (x0),
    .warmup_i   (warmup),
    .samples_i  (samples),
    .pt_valid_o (pt_valid_o),
    .pt_col_o   (pt_col_o),
    .pt_row_o   (pt_row_o),
    .pt_ready_i (pt_ready),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  // Reference logistic-map sweep: pushes the expected (col,row) of every emitted point.
  task automatic push_model(input longint mu_s, input longint step, input longint x_init,
                            input longint w, input longint s);
    longint mu, x, t, p;
    mu = mu_s;
    for (int c = 0; c < TB_COLS; c++) begin
      x = (x_init >= 65536) ? 65535 : x_init;
      for (int it = 1; it <= 2000; it++) begin
        t = (x * (65536 - x)) >> 16;
        p = (mu * t) >> 16;
        x = (p > 65535) ? 65535 : p;
        if (it > w && it <= w + s) begin
          exp_col.push_back(c);
          exp_row.push_back(int'((x * 480) >> 16));
        end
        if (it > w && it >= w + s) break;
      end
      mu = (mu + step > 262143) ? 262143 : mu + step;
    end
  endtask

  // Called at a negedge; start is sampled by the next posedge (edge 0), then inputs are scrambled.
  task automatic pulse_start(input logic [17:0] ms, input logic [17:0] st, input logic [16:0] xi,
                             input logic [8:0] w, input logic [8:0] s);
    mu_start = ms;
    mu_step  = st;
    x0       = xi;
    warmup   = w;
    samples  = s;
    start    = 1'b1;
    @(negedge CLK);
    start    = 1'b0;
    mu_start = 18'($urandom);
    mu_step  = 18'($urandom);
    x0       = 17'($urandom);
    warmup   = 9'($urandom);
    samples  = 9'($urandom);
    cyc      = 0;
  endtask

  // Scoreboard consumer: compares every handshaken point until done or the cycle budget expires.
  task automatic consume(input int budget);
    int ec, er;
    got_done = 1'b0;
    done_cyc = -1;
    n_points = 0;
    while (!got_done && cyc < budget) begin
      if (pt_valid_o && pt_ready) begin
        n_points++;
        n_checks++;
        if (exp_col.size() == 0) begin
          n_errors++;
          $display("FAIL extra_point: got col=%0d row=%0d, expected no point", pt_col_o, pt_row_o);
        end else begin
          ec = exp_col.pop_front();
          er = exp_row.pop_front();
          if (pt_col_o !== 10'(ec) || pt_row_o !== 10'(er)) begin
            n_errors++;
            $display("FAIL point: got col=%0d row=%0d, expected col=%0d row=%0d",
                     pt_col_o, pt_row_o, ec, er);
          end
        end
      end
      if (done_o) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end else begin
        @(negedge CLK);
        cyc++;
      end
    end
    n_checks++;
    if (!got_done) begin
      n_errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  // Common end-of-run checks: scoreboard drained, busy low with done, done lasts one cycle.
  task automatic finish_run(input string name);
    n_checks++;
    if (exp_col.size() != 0) begin
      n_errors++;
      $display("FAIL %s_missing: %0d expected points never emitted", name, exp_col.size());
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_busy_at_done: got %b expected 0", name, busy_o);
    end
    @(negedge CLK);
    n_checks++;
    if (done_o !== 1'b0 || pt_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_after_done: got done=%b pt_valid=%b expected 0 0", name, done_o, pt_valid_o);
    end
    exp_col.delete();
    exp_row.delete();
  endtask

  task automatic test_reset();
    RST      = 1'b0;
    start    = 1'b0;
    pt_ready = 1'b0;
    mu_start = '0;
    mu_step  = '0;
    x0       = '0;
    warmup   = '0;
    samples  = '0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (pt_valid_o !== 1'b0 || pt_col_o !== 10'd0 || pt_row_o !== 10'd0 ||
        busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got valid=%b col=%0d row=%0d busy=%b done=%b expected all 0",
               pt_valid_o, pt_col_o, pt_row_o, busy_o, done_o);
    end
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_fixed_point();
    pt_ready = 1'b1;
    push_model(64'h20000, 0, 64'h8000, 3, 2);
    pulse_start(18'h20000, 18'h0, 17'h08000, 9'd3, 9'd2);
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_errors++;
      $display("FAIL fixed_busy: got %b expected 1 after start", busy_o);
    end
    consume(BUDGET);
    n_checks++;
    if (n_points != 2 * TB_COLS) begin
      n_errors++;
      $display("FAIL fixed_count: got %0d points expected %0d", n_points, 2 * TB_COLS);
    end
    finish_run("fixed");
  endtask

  task automatic test_decay_and_start_ignored();
    pt_ready = 1'b0;
    push_model(64'h10000, 0, 64'h8000, 0, 2);
    pulse_start(18'h10000, 18'h0, 17'h08000, 9'd0, 9'd2);
    // A second start while busy must not restart the sweep or reload parameters.
    mu_start = 18'h0;
    start    = 1'b1;
    @(negedge CLK);
    cyc++;
    start    = 1'b0;
    pt_ready = 1'b1;
    consume(BUDGET);
    n_checks++;
    if (n_points != 2 * TB_COLS) begin
      n_errors++;
      $display("FAIL decay_count: got %0d points expected %0d", n_points, 2 * TB_COLS);
    end
    finish_run("decay");
  endtask

  task automatic test_latency_samples_zero();
    // warmup=4: first point registered by edge 2*4+3 = 11.
    pt_ready = 1'b0;
    push_model(64'h20000, 0, 64'h8000, 4, 1);
    pulse_start(18'h20000, 18'h0, 17'h08000, 9'd4, 9'd1);
    while (!pt_valid_o && cyc < 40) begin
      @(negedge CLK);
      cyc++;
    end
    n_checks++;
    if (cyc != 11) begin
      n_errors++;
      $display("FAIL first_valid_latency: got edge %0d expected 11", cyc);
    end
    pt_ready = 1'b1;
    consume(BUDGET);
    finish_run("latency");
    // samples=0: per column LOAD, warmup+1 TERM/MULT pairs (the pair ending warm-up exits to NEXT), NEXT.
    pulse_start(18'h20000, 18'h0, 17'h08000, 9'd4, 9'd0);
    consume(BUDGET);
    n_checks++;
    if (n_points != 0) begin
      n_errors++;
      $display("FAIL zero_samples_points: got %0d points expected 0", n_points);
    end
    n_checks++;
    if (done_cyc != TB_COLS * (2 * 4 + 4)) begin
      n_errors++;
      $display("FAIL zero_samples_done_edge: got %0d expected %0d", done_cyc, TB_COLS * 12);
    end
    finish_run("zero_samples");
  endtask

  task automatic test_backpressure();
    int c0, r0;
    pt_ready = 1'b0;
    push_model(64'h20000, 0, 64'h8000, 3, 2);
    pulse_start(18'h20000, 18'h0, 17'h08000, 9'd3, 9'd2);
    while (!pt_valid_o && cyc < 100) begin
      @(negedge CLK);
      cyc++;
    end
    n_checks++;
    if (cyc != 9) begin
      n_errors++;
      $display("FAIL bp_first_valid: got edge %0d expected 9", cyc);
    end
    c0 = int'(pt_col_o);
    r0 = int'(pt_row_o);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      cyc++;
      n_checks++;
      if (pt_valid_o !== 1'b1 || pt_col_o !== 10'(c0) || pt_row_o !== 10'(r0)) begin
        n_errors++;
        $display("FAIL bp_hold: got valid=%b col=%0d row=%0d expected 1 %0d %0d",
                 pt_valid_o, pt_col_o, pt_row_o, c0, r0);
      end
    end
    pt_ready = 1'b1;
    consume(BUDGET);
    n_checks++;
    if (n_points != 2 * TB_COLS) begin
      n_errors++;
      $display("FAIL bp_count: got %0d points expected %0d", n_points, 2 * TB_COLS);
    end
    finish_run("bp");
  endtask

  task automatic test_saturation_and_zero();
    pt_ready = 1'b1;
    push_model(64'h3FF00, 64'h100, 64'h8000, 2, 2);
    pulse_start(18'h3FF00, 18'h00100, 17'h08000, 9'd2, 9'd2);
    consume(BUDGET);
    finish_run("mu_sat");
    push_model(0, 0, 64'h10000, 1, 1);
    pulse_start(18'h0, 18'h0, 17'h10000, 9'd1, 9'd1);
    consume(BUDGET);
    finish_run("mu_zero");
    push_model(64'h20000, 64'h800, 64'h1C000, 0, 1);
    pulse_start(18'h20000, 18'h00800, 17'h1C000, 9'd0, 9'd1);
    consume(BUDGET);
    finish_run("x_clamp");
  endtask

  task automatic test_reset_mid_run();
    pt_ready = 1'b0;
    pulse_start(18'h20000, 18'h0, 17'h08000, 9'd3, 9'd2);
    while (!pt_valid_o && cyc < 100) begin
      @(negedge CLK);
      cyc++;
    end
    RST = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (pt_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset: got valid=%b busy=%b done=%b expected 0 0 0",
               pt_valid_o, busy_o, done_o);
    end
    RST = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK);
      n_checks++;
      if (pt_valid_o !== 1'b0 || done_o !== 1'b0) begin
        n_errors++;
        $display("FAIL post_reset_idle: got valid=%b done=%b expected 0 0", pt_valid_o, done_o);
      end
    end
    pt_ready = 1'b1;
    push_model(64'h10000, 0, 64'h8000, 0, 2);
    pulse_start(18'h10000, 18'h0, 17'h08000, 9'd0, 9'd2);
    consume(BUDGET);
    finish_run("rerun");
  endtask

  initial begin
    test_reset();
    test_fixed_point();
    test_decay_and_start_ignored();
    test_latency_samples_zero();
    test_backpressure();
    test_saturation_and_zero();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
